// File: rtl/nibble_serializer.sv
`default_nettype none
//==============================================================================
// Module      : nibble_serializer
// Description : Accepts a WORD_W-bit word over a valid/ready handshake and
//               emits it as WORD_W/NIB_W nibbles, least-significant nibble
//               first, one per accepted output beat. A new word can be
//               accepted in the same cycle the final nibble of the current
//               word handshakes, so back-to-back words stream with no bubble.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   WORD_W     input word width (integer multiple of NIB_W, >= 2*NIB_W)
//   NIB_W      output nibble width
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   upstream word valid
//   in_ready   out  block can accept a word this cycle
//   in_data    in   word to serialise, sampled only on the input handshake
//   out_valid  out  out_data holds a valid nibble
//   out_ready  in   downstream accepts the nibble
//   out_data   out  current nibble (0 when no word is held)
//   out_last   out  current nibble is the final nibble of its word
//   out_par    out  even parity of out_data (only when NIBSER_PARITY_EN)
//   busy       out  a word is held
// Configuration
//   NIBSER_PARITY_EN  defined: adds the out_par port.
//==============================================================================
module nibble_serializer #(
   parameter int WORD_W = 16,
   parameter int NIB_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NIB_W-1:0]  out_data,
   output logic              out_last,
`ifdef NIBSER_PARITY_EN
   output logic              out_par,
`endif
   output logic              busy
);

   localparam int                c_n        = WORD_W / NIB_W;
   localparam int                c_cnt_w    = $clog2(c_n);
   localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_n - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   shreg_q, shreg_d;
   logic [c_cnt_w-1:0]  cnt_q,   cnt_d;

   logic                held;
   logic                at_last;
   logic                in_hs;
   logic                out_hs;

   // Outputs are forced quiet whenever reset is asserted, so nothing from an
   // interrupted word is visible even in the cycle reset is first applied.
   assign held      = rst_n & (state_q == S_SHIFT);
   assign at_last   = (cnt_q == c_last_cnt);

   assign out_valid = held;
   assign busy      = held;
   assign out_data  = held ? shreg_q[NIB_W-1:0] : '0;
   assign out_last  = held & at_last;

   assign out_hs    = out_valid & out_ready;
   // Ready either when empty or when the final nibble leaves this cycle.
   assign in_ready  = rst_n & ((state_q == S_IDLE) | (out_hs & at_last));
   assign in_hs     = in_valid & in_ready;

`ifdef NIBSER_PARITY_EN
   assign out_par   = ^out_data;
`endif

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_hs) begin
               shreg_d = in_data;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (out_hs) begin
               if (!at_last) begin
                  shreg_d = shreg_q >> NIB_W;
                  cnt_d   = cnt_q + c_cnt_w'(1);
               end else if (in_hs) begin
                  // Reload in the drain cycle: next word starts without a gap.
                  shreg_d = in_data;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serializer.sv
`default_nettype none
//==============================================================================
// Module      : tb_nibble_serializer
// Description : Self-checking bench for nibble_serializer. A queue of pending
//               nibbles models the block; directed scenarios pin the model
//               with literal expectations, then randomized traffic follows.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_nibble_serializer;

   localparam int WORD_W = 16;
   localparam int NIB_W  = 4;
   localparam int N      = WORD_W / NIB_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WORD_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [NIB_W-1:0]  out_data;
   logic              out_last;
   logic              busy;
`ifdef NIBSER_PARITY_EN
   logic              out_par;
`endif

   nibble_serializer #(.WORD_W(WORD_W), .NIB_W(NIB_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
`ifdef NIBSER_PARITY_EN
      .out_par   (out_par),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Model: nibbles of the held word still to be emitted, front = current.
   logic [NIB_W-1:0] model_q[$];
   // Nibbles observed leaving the DUT on an output handshake.
   logic [NIB_W-1:0] hs_log[$];
   logic             obs_in_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs after the falling edge, compare outputs
   // against the model, then advance the model across the rising edge.
   task automatic step(input logic rv, input logic iv, input logic [WORD_W-1:0] id,
                       input logic ordy);
      logic             e_valid, e_last, e_ready;
      logic [NIB_W-1:0] e_data;
      @(negedge clk);
      rst_n = rv; in_valid = iv; in_data = id; out_ready = ordy;
      #1;
      e_valid = rv && (model_q.size() > 0);
      e_data  = e_valid ? model_q[0] : '0;
      e_last  = e_valid && (model_q.size() == 1);
      e_ready = rv && ((model_q.size() == 0) || (ordy && model_q.size() == 1));
      check("out_valid", 32'(out_valid), 32'(e_valid));
      check("out_data",  32'(out_data),  32'(e_data));
      check("out_last",  32'(out_last),  32'(e_last));
      check("busy",      32'(busy),      32'(e_valid));
      check("in_ready",  32'(in_ready),  32'(e_ready));
`ifdef NIBSER_PARITY_EN
      check("out_par",   32'(out_par),   32'(^e_data));
`endif
      obs_in_ready = in_ready;
      if (out_valid && ordy) hs_log.push_back(out_data);
      @(posedge clk);
      if (!rv) begin
         model_q.delete();
      end else begin
         if (e_valid && ordy) void'(model_q.pop_front());
         if (iv && e_ready)
            for (int i = 0; i < N; i++) model_q.push_back(id[i*NIB_W +: NIB_W]);
      end
   endtask

   task automatic check_log(input string name, input logic [WORD_W-1:0] exp_nibs, input int cnt);
      check({name, "_len"}, 32'(hs_log.size()), 32'(cnt));
      for (int i = 0; i < cnt && i < hs_log.size(); i++)
         check(name, 32'(hs_log[i]), 32'(exp_nibs[i*NIB_W +: NIB_W]));
      hs_log.delete();
   endtask

   initial begin
      logic [WORD_W-1:0] w;
      logic [31:0]       b2b;

      // Reset held two cycles with in_valid asserted.
      step(1'b0, 1'b1, 16'hFFFF, 1'b1);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      step(1'b0, 1'b1, 16'hFFFF, 1'b1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      hs_log.delete();

      // Single word, out_ready high: C,5,A,9 then idle.
      step(1'b1, 1'b1, 16'h9A5C, 1'b1);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      check("single_first", 32'(out_data), 32'hC);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      check("single_last_early", 32'(out_last), 32'd0);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      check("single_last", 32'(out_last), 32'd1);
      check("single_nib9", 32'(out_data), 32'h9);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      check("single_idle", 32'(out_valid), 32'd0);
      check_log("single_seq", 16'h9A5C, 4);

      // Backpressure: 4,3,2,1 exactly once each despite stalls.
      step(1'b1, 1'b1, 16'h1234, 1'b1);
      for (int i = 0; i < 12; i++)
         step(1'b1, 1'b0, 16'h0000, (i % 3) == 0);
      check_log("bp_seq", 16'h1234, 4);

      // Back-to-back: second word taken on the F handshake, no idle cycle.
      step(1'b1, 1'b1, 16'hFEDC, 1'b1);
      step(1'b1, 1'b1, 16'h0001, 1'b1);
      step(1'b1, 1'b1, 16'h0001, 1'b1);
      step(1'b1, 1'b1, 16'h0001, 1'b1);
      step(1'b1, 1'b1, 16'h0001, 1'b1);
      check("b2b_accept_on_F", 32'(obs_in_ready), 32'd1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);
      b2b = 32'h0001FEDC;
      check("b2b_len", 32'(hs_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < hs_log.size(); i++)
         check("b2b_seq", 32'(hs_log[i]), 32'(b2b[i*NIB_W +: NIB_W]));
      hs_log.delete();

      // Mid-word reset after nibble 5, then a fresh word.
      step(1'b1, 1'b1, 16'h9A5C, 1'b1);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      check("midrst_valid", 32'(out_valid), 32'd0);
      hs_log.delete();
      step(1'b1, 1'b1, 16'h0007, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);
      check_log("midrst_seq", 16'h0007, 4);

`ifdef NIBSER_PARITY_EN
      // Parity: 1,0,3,7 -> 1,0,0,1.
      step(1'b1, 1'b1, 16'h7301, 1'b1);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      check("par0", 32'(out_par), 32'd1);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      check("par1", 32'(out_par), 32'd0);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      check("par2", 32'(out_par), 32'd0);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      check("par3", 32'(out_par), 32'd1);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
`endif

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         w = WORD_W'($urandom);
         step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), w,
              ($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
